// File: rtl/mole_game_pkg.sv
// Shared types and helpers for the whack-a-mole game sequencer.
package mole_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_UP   = 3'd2,
        ST_HIT  = 3'd3,
        ST_OVER = 3'd4
    } state_e;

    localparam logic [2:0] NO_HOLE   = 3'd7;
    localparam int         NUM_HOLES = 5;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Reduce a 3-bit value into 0..4 (5->0, 6->1, 7->2).
    function automatic logic [2:0] fold_hole(input logic [2:0] v);
        logic [2:0] r;
        if (v >= 3'(NUM_HOLES)) begin
            r = v - 3'(NUM_HOLES);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // (h + 1) mod 5 for a hole already in 0..4.
    function automatic logic [2:0] next_hole(input logic [2:0] h);
        logic [2:0] r;
        if (h == 3'(NUM_HOLES - 1)) begin
            r = 3'd0;
        end else begin
            r = h + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR producing a pseudo-random hole index in 0..4.
module mole_lfsr
    import mole_game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [2:0] hole_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb_s;

    // Next LFSR value: shift left, feed the XOR of the tapped bits into bit 0.
    always_comb begin
        fb_s = ^(lfsr_q & LFSR_TAPS);
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], fb_s};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register, reloaded with the seed on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign hole_o = fold_hole(lfsr_q[2:0]);

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: picks the mole hole, times show/gap/hit phases in
// video frames, scores hits and ends the game after too many misses.
module mole_scheduler
    import mole_game_pkg::*;
#(
    parameter int unsigned SHOW_FRAMES = 60,
    parameter int unsigned GAP_FRAMES  = 30,
    parameter int unsigned HIT_FRAMES  = 15,
    parameter int unsigned MAX_MISSES  = 5,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_frame,
    input  logic       start,
    input  logic       whack_valid,
    input  logic [2:0] whack_hole,
    output logic [2:0] oval_select,
    output logic       mole_up,
    output logic       hit_flash,
    output logic [7:0] score,
    output logic [2:0] misses,
    output logic       game_over
);

    localparam int unsigned MAX_SG = (SHOW_FRAMES > GAP_FRAMES) ? SHOW_FRAMES : GAP_FRAMES;
    localparam int unsigned MAX_F  = (MAX_SG > HIT_FRAMES) ? MAX_SG : HIT_FRAMES;
    localparam int unsigned CNT_W  = $clog2(MAX_F + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         oval_q, oval_d;
    logic               mole_q, mole_d;
    logic               hit_q, hit_d;
    logic [7:0]         score_q, score_d;
    logic [2:0]         misses_q, misses_d;
    logic               over_q, over_d;
    logic [2:0]         prev_q, prev_d;

    logic [2:0]         cand_s;
    logic [2:0]         pick_s;
    logic               expire_s;
    logic               hit_s;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .hole_o (cand_s)
    );

    // Hole choice and phase-expiry / hit qualifiers.
    always_comb begin
        if (cand_s == prev_q) begin
            pick_s = next_hole(cand_s);
        end else begin
            pick_s = cand_s;
        end
        expire_s = tick_frame && (cnt_q == CNT_W'(1));
        hit_s    = whack_valid && (whack_hole == oval_q);
    end

    // Next-state, counter, display and score logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        oval_d   = oval_q;
        mole_d   = mole_q;
        hit_d    = hit_q;
        score_d  = score_q;
        misses_d = misses_q;
        over_d   = over_q;
        prev_d   = prev_q;

        if (tick_frame && (cnt_q != CNT_W'(0))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                oval_d = NO_HOLE;
                if (start) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_FRAMES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                oval_d = NO_HOLE;
                if (expire_s) begin
                    state_d = ST_UP;
                    cnt_d   = CNT_W'(SHOW_FRAMES);
                    mole_d  = 1'b1;
                    oval_d  = pick_s;
                    prev_d  = pick_s;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_UP: begin
                // A matching strike wins over a simultaneous expiry.
                if (hit_s) begin
                    state_d = ST_HIT;
                    cnt_d   = CNT_W'(HIT_FRAMES);
                    mole_d  = 1'b0;
                    hit_d   = 1'b1;
                    if (score_q == 8'd255) begin
                        score_d = 8'd255;
                    end else begin
                        score_d = score_q + 8'd1;
                    end
                end else if (expire_s) begin
                    misses_d = misses_q + 3'd1;
                    mole_d   = 1'b0;
                    oval_d   = NO_HOLE;
                    if ((misses_q + 3'd1) == 3'(MAX_MISSES)) begin
                        state_d = ST_OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP_FRAMES);
                    end
                end else begin
                    state_d = ST_UP;
                end
            end
            ST_HIT: begin
                if (expire_s) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_FRAMES);
                    hit_d   = 1'b0;
                    oval_d  = NO_HOLE;
                end else begin
                    state_d = ST_HIT;
                end
            end
            ST_OVER: begin
                over_d = 1'b1;
                oval_d = NO_HOLE;
                if (start) begin
                    state_d  = ST_GAP;
                    cnt_d    = CNT_W'(GAP_FRAMES);
                    score_d  = 8'd0;
                    misses_d = 3'd0;
                    over_d   = 1'b0;
                    prev_d   = NO_HOLE;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = CNT_W'(0);
                oval_d   = NO_HOLE;
                mole_d   = 1'b0;
                hit_d    = 1'b0;
                over_d   = 1'b0;
                prev_d   = NO_HOLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_W'(0);
            oval_q   <= NO_HOLE;
            mole_q   <= 1'b0;
            hit_q    <= 1'b0;
            score_q  <= 8'd0;
            misses_q <= 3'd0;
            over_q   <= 1'b0;
            prev_q   <= NO_HOLE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oval_q   <= oval_d;
            mole_q   <= mole_d;
            hit_q    <= hit_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            over_q   <= over_d;
            prev_q   <= prev_d;
        end
    end

    assign oval_select = oval_q;
    assign mole_up     = mole_q;
    assign hit_flash   = hit_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a reference LFSR for hole prediction.
module tb_mole_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_frame = 1'b0;
    logic       start = 1'b0;
    logic       whack_valid = 1'b0;
    logic [2:0] whack_hole = 3'd0;
    logic [2:0] oval_select;
    logic       mole_up;
    logic       hit_flash;
    logic [7:0] score;
    logic [2:0] misses;
    logic       game_over;

    mole_scheduler #(
        .SHOW_FRAMES (4),
        .GAP_FRAMES  (2),
        .HIT_FRAMES  (3),
        .MAX_MISSES  (2),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_frame  (tick_frame),
        .start       (start),
        .whack_valid (whack_valid),
        .whack_hole  (whack_hole),
        .oval_select (oval_select),
        .mole_up     (mole_up),
        .hit_flash   (hit_flash),
        .score       (score),
        .misses      (misses),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 8,6,5,4, advancing every cycle out of reset.
    logic [7:0] model_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) model_lfsr <= 8'hA5;
        else     model_lfsr <= {model_lfsr[6:0],
                                model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_hole = 3'd7;
    logic [2:0] exp_prev = 3'd7;
    logic [7:0] snap;

    typedef struct {
        logic       t;      // tick_frame
        logic       s;      // start
        logic [1:0] w;      // 0 none, 1 strike mole hole, 2 strike another hole
        logic [1:0] kind;   // 0 no mole, 1 hole held, 2 new hole picked
        logic       clr;    // game restart clears previous-hole memory
        logic       mole;
        logic       hf;
        logic [7:0] sc;
        logic [2:0] mi;
        logic       go;
    } vec_t;

    vec_t tbl[35];

    function automatic vec_t mk(logic t, logic s, logic [1:0] w, logic [1:0] kind, logic clr,
                                logic mole, logic hf, logic [7:0] sc, logic [2:0] mi, logic go);
        vec_t v;
        v.t = t; v.s = s; v.w = w; v.kind = kind; v.clr = clr;
        v.mole = mole; v.hf = hf; v.sc = sc; v.mi = mi; v.go = go;
        return v;
    endfunction

    function automatic logic [2:0] fold(input logic [2:0] v);
        return (v >= 3'd5) ? (v - 3'd5) : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then update and check the expected hole.
    task automatic do_step(input logic t, input logic s, input logic [1:0] w,
                           input logic [1:0] kind, input logic clr, input int idle,
                           input string tag);
        logic [2:0] c;
        @(negedge clk);
        tick_frame  = t;
        start       = s;
        whack_valid = (w != 2'd0);
        if (w == 2'd1)          whack_hole = exp_hole;
        else if (exp_hole < 3'd5) whack_hole = (exp_hole == 3'd4) ? 3'd0 : exp_hole + 3'd1;
        else                    whack_hole = 3'd0;
        snap = model_lfsr;
        @(negedge clk);
        tick_frame  = 1'b0;
        start       = 1'b0;
        whack_valid = 1'b0;
        whack_hole  = 3'd0;
        if (clr) exp_prev = 3'd7;
        case (kind)
            2'd0: exp_hole = 3'd7;
            2'd2: begin
                c = fold(snap[2:0]);
                if (c == exp_prev) c = (c == 3'd4) ? 3'd0 : c + 3'd1;
                exp_hole = c;
                exp_prev = c;
            end
            default: ;
        endcase
        chk({tag, " oval_select"}, int'(oval_select), int'(exp_hole));
        repeat (idle) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic mole, input logic hf,
                            input logic [7:0] sc, input logic [2:0] mi, input logic go);
        chk({tag, " mole_up"},   int'(mole_up),   int'(mole));
        chk({tag, " hit_flash"}, int'(hit_flash), int'(hf));
        chk({tag, " score"},     int'(score),     int'(sc));
        chk({tag, " misses"},    int'(misses),    int'(mi));
        chk({tag, " game_over"}, int'(game_over), int'(go));
    endtask

    initial begin
        logic [2:0] last_hole;
        logic [7:0] exp_sc;
        string tag;

        //               t     s     w     kind  clr   mole  hf    score misses go
        tbl[0]  = mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1, 3'd1, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1, 3'd1, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1, 3'd1, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd1, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd1, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 3'd1, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 3'd1, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 3'd1, 1'b0);
        tbl[19] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 3'd1, 1'b0);
        tbl[20] = mk(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2, 3'd1, 1'b0);
        tbl[21] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2, 3'd1, 1'b0);
        tbl[22] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd2, 3'd1, 1'b0);
        tbl[23] = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd1, 1'b0);
        tbl[24] = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd1, 1'b0);
        tbl[25] = mk(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd2, 3'd1, 1'b0);
        tbl[26] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 3'd1, 1'b0);
        tbl[27] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 3'd1, 1'b0);
        tbl[28] = mk(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 3'd1, 1'b0);
        tbl[29] = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd2, 1'b1);
        tbl[30] = mk(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd2, 1'b1);
        tbl[31] = mk(1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd2, 1'b1);
        tbl[32] = mk(1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[33] = mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        tbl[34] = mk(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Main game walk: miss, hit, hit on expiry tick, game over, restart.
        for (int i = 0; i < 35; i++) begin
            tag = $sformatf("vec%0d", i);
            do_step(tbl[i].t, tbl[i].s, tbl[i].w, tbl[i].kind, tbl[i].clr, 8, tag);
            chk_outs(tag, tbl[i].mole, tbl[i].hf, tbl[i].sc, tbl[i].mi, tbl[i].go);
        end

        // Repeated appearances via hits until the score saturates at 255.
        last_hole = exp_hole;
        for (int k = 0; k < 256; k++) begin
            exp_sc = (k >= 255) ? 8'd255 : 8'(k + 1);
            do_step(1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1, $sformatf("hit%0d", k));
            chk($sformatf("hit%0d score", k), int'(score), int'(exp_sc));
            chk($sformatf("hit%0d hit_flash", k), int'(hit_flash), 1);
            do_step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1, "hold1");
            do_step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1, "hold2");
            do_step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1, "hitend");
            do_step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1, "gap1");
            do_step(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1, $sformatf("appear%0d", k));
            chk($sformatf("appear%0d repeat", k), int'(oval_select != last_hole), 1);
            chk($sformatf("appear%0d range", k), int'(oval_select < 3'd5), 1);
            chk($sformatf("appear%0d mole_up", k), int'(mole_up), 1);
            last_hole = oval_select;
        end

        // Asynchronous reset between clock edges while the mole is up.
        do_step(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 0, "preRst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_hole = 3'd7;
        exp_prev = 3'd7;
        chk("rst oval_select", int'(oval_select), 7);
        chk_outs("rst", 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh game after the reset.
        do_step(1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 4, "new_start");
        chk_outs("new_start", 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        do_step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4, "new_gap");
        do_step(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 4, "new_up");
        chk_outs("new_up", 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
        do_step(1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 4, "new_hit");
        chk_outs("new_hit", 1'b0, 1'b1, 8'd1, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
